// File: rtl/mac_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module  : mac_ctrl_pkg
// Brief   : Shared state encoding and defaults for the MAC job sequencer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mac_ctrl_pkg;

    localparam int C_K_W_DEFAULT     = 16;
    localparam int C_TIMEOUT_DEFAULT = 100;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_ACK    = 3'd4,
        ST_RESULT = 3'd5,
        ST_ERR    = 3'd6
    } mac_job_state_e;

    // Counter width able to hold values 0..t.
    function automatic int wd_width(input int t);
        if (t < 2) begin
            return 1;
        end
        return $clog2(t + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mac_watchdog.sv
//------------------------------------------------------------------------------
// Module  : mac_watchdog
// Brief   : Saturating cycle counter; expired after TIMEOUT enabled cycles.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mac_watchdog
    import mac_ctrl_pkg::*;
#(
    parameter int TIMEOUT = C_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int            CW     = wd_width(TIMEOUT);
    localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != C_LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the number of enabled cycles already elapsed, so the
    // TIMEOUT-th enabled cycle is the one that sees C_LAST.
    assign expired_o = (cnt_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/mac_job_ctrl.sv
//------------------------------------------------------------------------------
// Module  : mac_job_ctrl
// Brief   : Job sequencer feeding one mac_cell pair-by-pair with a watchdog.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mac_job_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int K_W     = C_K_W_DEFAULT,
    parameter int TIMEOUT = C_TIMEOUT_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [K_W-1:0] start_k,
    input  logic           start_mode_fp8,
    input  logic           start_bf16,
    output logic           busy,
    input  logic           op_valid,
    output logic           op_ready,
    input  logic [7:0]     op_a,
    input  logic [7:0]     op_b,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [15:0]    res_data,
    output logic [K_W-1:0] pairs_done,
    output logic           err_timeout,
    input  logic           err_clr,
    output logic           cell_mode_fp8,
    output logic           cell_out_bf16_en,
    output logic [7:0]     cell_a_raw,
    output logic [7:0]     cell_b_raw,
    output logic           cell_a_valid_in,
    output logic           cell_mac_valid_in,
    output logic           cell_output_ready,
    input  logic           cell_input_ready_take,
    input  logic           cell_mac_valid,
    input  logic [15:0]    cell_mac_packed_bf
);

    mac_job_state_e state_q;
    mac_job_state_e state_d;

    logic [K_W-1:0] k_q;
    logic [K_W-1:0] k_d;
    logic [K_W-1:0] pairs_q;
    logic [K_W-1:0] pairs_d;
    logic [K_W-1:0] pairs_inc;
    logic           mode_q;
    logic           mode_d;
    logic           bf16_q;
    logic           bf16_d;
    logic [7:0]     a_q;
    logic [7:0]     a_d;
    logic [7:0]     b_q;
    logic [7:0]     b_d;
    logic [15:0]    res_q;
    logic [15:0]    res_d;

    logic           wd_clear;
    logic           wd_enable;
    logic           wd_expired;

    mac_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .expired_o (wd_expired)
    );

    assign pairs_inc = pairs_q + K_W'(1);

    always_comb begin
        state_d           = state_q;
        k_d               = k_q;
        pairs_d           = pairs_q;
        mode_d            = mode_q;
        bf16_d            = bf16_q;
        a_d               = a_q;
        b_d               = b_q;
        res_d             = res_q;
        busy              = 1'b0;
        op_ready          = 1'b0;
        res_valid         = 1'b0;
        err_timeout       = 1'b0;
        cell_a_valid_in   = 1'b0;
        cell_mac_valid_in = 1'b0;
        cell_output_ready = 1'b0;
        wd_clear          = 1'b0;
        wd_enable         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A zero-length job is dropped rather than producing a result.
                if (start && (start_k != '0)) begin
                    k_d     = start_k;
                    mode_d  = start_mode_fp8;
                    bf16_d  = start_bf16;
                    pairs_d = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                busy     = 1'b1;
                op_ready = cell_input_ready_take;
                if (op_valid && cell_input_ready_take) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                busy              = 1'b1;
                cell_a_valid_in   = 1'b1;
                cell_mac_valid_in = 1'b1;
                wd_clear          = 1'b1;
                state_d           = ST_WAIT;
            end
            ST_WAIT: begin
                busy      = 1'b1;
                wd_enable = 1'b1;
                if (cell_mac_valid) begin
                    res_d   = cell_mac_packed_bf;
                    state_d = ST_ACK;
                end else if (wd_expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_ACK: begin
                busy              = 1'b1;
                cell_output_ready = 1'b1;
                pairs_d           = pairs_inc;
                state_d           = (pairs_inc == k_q) ? ST_RESULT : ST_FETCH;
            end
            ST_RESULT: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: begin
                err_timeout = 1'b1;
                if (err_clr) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output format defaults to BF16 until the first job says otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q     <= '0;
            pairs_q <= '0;
            mode_q  <= 1'b0;
            bf16_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            k_q     <= k_d;
            pairs_q <= pairs_d;
            mode_q  <= mode_d;
            bf16_q  <= bf16_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    assign res_data         = res_q;
    assign pairs_done       = pairs_q;
    assign cell_mode_fp8    = mode_q;
    assign cell_out_bf16_en = bf16_q;
    assign cell_a_raw       = a_q;
    assign cell_b_raw       = b_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_job_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_mac_job_ctrl
// Brief   : Self-checking bench for mac_job_ctrl with a behavioural mac_cell.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mac_job_ctrl;

    localparam int K_W     = 16;
    localparam int TIMEOUT = 100;

    logic           clk;
    logic           rst;
    logic           start;
    logic [K_W-1:0] start_k;
    logic           start_mode_fp8;
    logic           start_bf16;
    logic           busy;
    logic           op_valid;
    logic           op_ready;
    logic [7:0]     op_a;
    logic [7:0]     op_b;
    logic           res_valid;
    logic           res_ready;
    logic [15:0]    res_data;
    logic [K_W-1:0] pairs_done;
    logic           err_timeout;
    logic           err_clr;
    logic           cell_mode_fp8;
    logic           cell_out_bf16_en;
    logic [7:0]     cell_a_raw;
    logic [7:0]     cell_b_raw;
    logic           cell_a_valid_in;
    logic           cell_mac_valid_in;
    logic           cell_output_ready;
    logic           cell_input_ready_take;
    logic           cell_mac_valid;
    logic [15:0]    cell_mac_packed_bf;

    mac_job_ctrl #(
        .K_W     (K_W),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk                   (clk),
        .rst                   (rst),
        .start                 (start),
        .start_k               (start_k),
        .start_mode_fp8        (start_mode_fp8),
        .start_bf16            (start_bf16),
        .busy                  (busy),
        .op_valid              (op_valid),
        .op_ready              (op_ready),
        .op_a                  (op_a),
        .op_b                  (op_b),
        .res_valid             (res_valid),
        .res_ready             (res_ready),
        .res_data              (res_data),
        .pairs_done            (pairs_done),
        .err_timeout           (err_timeout),
        .err_clr               (err_clr),
        .cell_mode_fp8         (cell_mode_fp8),
        .cell_out_bf16_en      (cell_out_bf16_en),
        .cell_a_raw            (cell_a_raw),
        .cell_b_raw            (cell_b_raw),
        .cell_a_valid_in       (cell_a_valid_in),
        .cell_mac_valid_in     (cell_mac_valid_in),
        .cell_output_ready     (cell_output_ready),
        .cell_input_ready_take (cell_input_ready_take),
        .cell_mac_valid        (cell_mac_valid),
        .cell_mac_packed_bf    (cell_mac_packed_bf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural cell configuration and observations.
    int          cell_lat      = 2;
    bit          cell_dead     = 1'b0;
    bit          cell_fixed_en = 1'b0;
    logic [15:0] cell_fixed    = 16'h0;
    logic [15:0] last_cell     = 16'h0;
    bit          op_fixed_en   = 1'b0;
    logic [15:0] issued_q[$];
    logic [15:0] sent_q[$];

    typedef struct {
        bit             st;
        logic [K_W-1:0] k;
        bit             mode;
        bit             bf16;
        bit             e_busy;
        bit             e_mode;
        bit             e_bf16;
    } start_vec_t;

    start_vec_t tv[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A mac_cell that answers each issued pair after cell_lat cycles.
    initial begin : cell_model
        int          ccnt;
        logic [15:0] d;
        ccnt               = 0;
        cell_mac_valid     = 1'b0;
        cell_mac_packed_bf = 16'h0;
        forever begin
            @(posedge clk);
            #3;
            if (rst) begin
                ccnt           = 0;
                cell_mac_valid = 1'b0;
            end else begin
                if (cell_output_ready) begin
                    cell_mac_valid = 1'b0;
                end
                if (cell_a_valid_in) begin
                    issued_q.push_back({cell_a_raw, cell_b_raw});
                    ccnt = cell_lat;
                end else if (ccnt > 0) begin
                    ccnt--;
                    if (ccnt == 0 && !cell_dead) begin
                        d                  = cell_fixed_en ? cell_fixed : 16'($urandom);
                        cell_mac_valid     = 1'b1;
                        cell_mac_packed_bf = d;
                        last_cell          = d;
                    end
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"},        busy,              0);
        chk({tag, "_op_ready"},    op_ready,          0);
        chk({tag, "_res_valid"},   res_valid,         0);
        chk({tag, "_err"},         err_timeout,       0);
        chk({tag, "_a_valid"},     cell_a_valid_in,   0);
        chk({tag, "_mac_valid"},   cell_mac_valid_in, 0);
        chk({tag, "_out_ready"},   cell_output_ready, 0);
        chk({tag, "_res_data"},    res_data,          0);
        chk({tag, "_pairs_done"},  pairs_done,        0);
        chk({tag, "_a_raw"},       cell_a_raw,        0);
        chk({tag, "_b_raw"},       cell_b_raw,        0);
        chk({tag, "_mode"},        cell_mode_fp8,     0);
        chk({tag, "_bf16"},        cell_out_bf16_en,  1);
    endtask

    // One full job: the scoreboard expects k issues carrying exactly the
    // accepted operands in order, and a final result equal to the k-th answer.
    task automatic run_job(input string tag, input int k, input bit mode, input bit bf16,
                           input int vpct, input int tpct, input int res_delay,
                           input int take_low, input bit intrude);
        bit done;
        bit prev_hs;
        bit prev_pend;
        int rescnt;
        sent_q.delete();
        issued_q.delete();
        chk({tag, "_idle_before"}, busy, 0);
        start          = 1'b1;
        start_k        = K_W'(k);
        start_mode_fp8 = mode;
        start_bf16     = bf16;
        op_valid       = 1'b0;
        res_ready      = 1'b0;
        tick();
        start = 1'b0;
        chk({tag, "_busy_accept"}, busy, 1);
        chk({tag, "_pairs_zero"}, pairs_done, 0);
        done      = 1'b0;
        prev_hs   = 1'b0;
        prev_pend = 1'b0;
        rescnt    = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            start = 1'b0;
            if (prev_hs) begin
                chk({tag, "_busy_drop"}, busy, 0);
                chk({tag, "_res_valid_drop"}, res_valid, 0);
                done = 1'b1;
                break;
            end
            chk({tag, "_mode_hold"}, cell_mode_fp8, mode);
            chk({tag, "_bf16_hold"}, cell_out_bf16_en, bf16);
            if (prev_pend) begin
                chk({tag, "_res_valid_held"}, res_valid, 1);
            end
            if (res_valid) begin
                chk({tag, "_res_data"}, res_data, last_cell);
                chk({tag, "_pairs_done"}, pairs_done, K_W'(k));
            end
            op_valid = ($urandom_range(99) < vpct);
            op_a     = op_fixed_en ? 8'h38 : 8'($urandom);
            op_b     = op_fixed_en ? 8'h38 : 8'($urandom);
            if (cyc < take_low) begin
                cell_input_ready_take = 1'b0;
                op_valid              = 1'b1;
            end else begin
                cell_input_ready_take = ($urandom_range(99) < tpct);
            end
            if (res_valid) begin
                rescnt++;
                res_ready = (rescnt > res_delay);
            end else begin
                res_ready = 1'($urandom);
            end
            if (intrude && $urandom_range(9) == 0) begin
                start          = 1'b1;
                start_k        = K_W'($urandom_range(1, 50));
                start_mode_fp8 = ~mode;
                start_bf16     = ~bf16;
            end
            #1;
            if (cyc < take_low) begin
                chk({tag, "_op_ready_blocked"}, op_ready, 0);
                chk({tag, "_no_issue"}, cell_a_valid_in, 0);
            end
            if (op_valid && op_ready) begin
                sent_q.push_back({op_a, op_b});
            end
            prev_hs   = res_valid && res_ready;
            prev_pend = res_valid && !res_ready;
            tick();
        end
        start     = 1'b0;
        op_valid  = 1'b0;
        res_ready = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: job did not complete within 3000 cycles", tag);
        end
        chk({tag, "_sent_count"}, sent_q.size(), k);
        chk({tag, "_issue_count"}, issued_q.size(), k);
        for (int i = 0; i < k; i++) begin
            if (i < issued_q.size() && i < sent_q.size()) begin
                chk({tag, "_issued_ops"}, issued_q[i], sent_q[i]);
            end
        end
    endtask

    initial begin : main
        int n;
        rst                   = 1'b1;
        start                 = 1'b0;
        start_k               = '0;
        start_mode_fp8        = 1'b0;
        start_bf16            = 1'b0;
        op_valid              = 1'b0;
        op_a                  = 8'h0;
        op_b                  = 8'h0;
        res_ready             = 1'b0;
        err_clr               = 1'b0;
        cell_input_ready_take = 1'b1;

        tick();
        tick();
        check_reset_vals("reset");
        rst = 1'b0;

        // start acceptance: {start, k, mode, bf16} -> {busy, mode, bf16}
        tv[0] = '{1'b0, 16'd3,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tv[1] = '{1'b1, 16'd0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tv[2] = '{1'b1, 16'd1,    1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tv[3] = '{1'b1, 16'd5,    1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[4] = '{1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tv[5] = '{1'b1, 16'd2,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            rst = 1'b1;
            tick();
            rst                   = 1'b0;
            cell_input_ready_take = 1'b1;
            op_valid              = 1'b0;
            start                 = tv[i].st;
            start_k               = tv[i].k;
            start_mode_fp8        = tv[i].mode;
            start_bf16            = tv[i].bf16;
            tick();
            start = 1'b0;
            chk($sformatf("tv%0d_busy", i), busy, tv[i].e_busy);
            chk($sformatf("tv%0d_mode", i), cell_mode_fp8, tv[i].e_mode);
            chk($sformatf("tv%0d_bf16", i), cell_out_bf16_en, tv[i].e_bf16);
            chk($sformatf("tv%0d_op_ready", i), op_ready, tv[i].e_busy);
            chk($sformatf("tv%0d_pairs", i), pairs_done, 0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Single pair, E4M3, 1.0 x 1.0 style operands with a fixed cell answer.
        op_fixed_en   = 1'b1;
        cell_fixed_en = 1'b1;
        cell_fixed    = 16'h3F80;
        cell_lat      = 2;
        run_job("k1", 1, 1'b0, 1'b1, 100, 100, 0, 0, 1'b0);
        chk("k1_result", res_data, 16'h3F80);
        chk("k1_a_raw", cell_a_raw, 8'h38);
        op_fixed_en   = 1'b0;
        cell_fixed_en = 1'b0;

        // Gappy operand stream and a downstream that stalls for three cycles.
        run_job("k4", 4, 1'b1, 1'b0, 50, 100, 3, 0, 1'b0);
        chk("k4_pairs_final", pairs_done, 4);

        // Cell not ready to take for the first five FETCH cycles.
        run_job("take", 2, 1'b0, 1'b1, 100, 100, 0, 5, 1'b0);

        // Foreign start requests during a job must not disturb it.
        run_job("intrude", 5, 1'b0, 1'b1, 80, 90, 1, 0, 1'b1);

        // Silent cell: watchdog trips after exactly TIMEOUT WAIT cycles.
        cell_dead             = 1'b1;
        cell_input_ready_take = 1'b1;
        start                 = 1'b1;
        start_k               = 16'd2;
        start_mode_fp8        = 1'b0;
        start_bf16            = 1'b1;
        op_valid              = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!cell_a_valid_in && n < 50) begin
            tick();
            n++;
        end
        chk("wd_issue_seen", cell_a_valid_in, 1);
        for (int i = 0; i < TIMEOUT; i++) begin
            tick();
        end
        chk("wd_not_yet", err_timeout, 0);
        tick();
        chk("wd_err", err_timeout, 1);
        chk("wd_op_ready", op_ready, 0);
        chk("wd_res_valid", res_valid, 0);
        chk("wd_a_valid", cell_a_valid_in, 0);
        tick();
        tick();
        chk("wd_sticky", err_timeout, 1);
        err_clr = 1'b1;
        op_valid = 1'b0;
        tick();
        err_clr = 1'b0;
        chk("wd_clr_err", err_timeout, 0);
        chk("wd_clr_busy", busy, 0);
        cell_dead = 1'b0;

        // Reset while waiting on the cell in the middle of an 8-pair job.
        op_fixed_en   = 1'b1;
        cell_fixed_en = 1'b1;
        cell_fixed    = 16'hBEEF;
        cell_lat      = 3;
        start         = 1'b1;
        start_k       = 16'd8;
        start_mode_fp8 = 1'b1;
        start_bf16    = 1'b0;
        op_a          = 8'h38;
        op_b          = 8'h38;
        op_valid      = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(pairs_done == 2 && cell_a_valid_in) && n < 500) begin
            tick();
            n++;
        end
        chk("rstw_reached", (pairs_done == 2 && cell_a_valid_in), 1);
        tick();
        chk("rstw_in_wait_busy", busy, 1);
        rst = 1'b1;
        tick();
        check_reset_vals("rstw");
        rst           = 1'b0;
        op_valid      = 1'b0;
        op_fixed_en   = 1'b0;
        cell_fixed_en = 1'b0;
        tick();

        // Randomised jobs against the scoreboard.
        for (int j = 0; j < 30; j++) begin
            cell_lat = $urandom_range(1, 5);
            run_job($sformatf("rnd%0d", j), $urandom_range(1, 6), 1'($urandom), 1'($urandom),
                    $urandom_range(40, 100), $urandom_range(50, 100),
                    $urandom_range(0, 3), 0, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
